opcode_extract: RTL and testbench

OPCODE_EXTRACT -- requirements
Module: opcode_extract

---
 rtl/decode_pkg.sv | 38 +++
 rtl/opcode_extract_if.sv | 30 +++
 rtl/prefix_classify.sv | 43 ++++
 rtl/opcode_extract.sv | 162 ++++++++++++++++
 tb/tb_opcode_extract.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants for the opcode extractor: legacy prefix byte
// values, the 0F escape byte, segment and rep field encodings, FSM states.
package decode_pkg;

  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_REPNE  = 8'hF2;
  localparam logic [7:0] PFX_REP    = 8'hF3;
  localparam logic [7:0] ESC_0F     = 8'h0F;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_e;

  typedef enum logic [1:0] {
    REP_NONE = 2'b00,
    REP_NE   = 2'b01,
    REP_E    = 2'b10
  } rep_e;

  typedef enum logic [1:0] {
    S_PFX  = 2'd0,
    S_ESC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/opcode_extract_if.sv
// Byte-stream input and held-opcode output of the opcode extractor.
// master: fetch unit / control store side; slave: the extractor.
interface opcode_extract_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] opcode;
  logic       opcode_size;
  logic       pfx_opsize;
  logic [1:0] pfx_rep;
  logic       pfx_lock;
  logic       seg_ovr;
  logic [2:0] pfx_seg;
  logic [2:0] pfx_count;
  logic       fault;

  modport master (
    output byte_valid, byte_data, op_ready,
    input  byte_ready, op_valid, opcode, opcode_size, pfx_opsize,
           pfx_rep, pfx_lock, seg_ovr, pfx_seg, pfx_count, fault
  );

  modport slave (
    input  byte_valid, byte_data, op_ready,
    output byte_ready, op_valid, opcode, opcode_size, pfx_opsize,
           pfx_rep, pfx_lock, seg_ovr, pfx_seg, pfx_count, fault
  );
endinterface

// File: rtl/prefix_classify.sv
// Pure combinational byte classifier: says whether a byte is a legacy
// prefix or the 0F escape, and which field a prefix writes.
module prefix_classify
  import decode_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_prefix_o,
  output logic       is_escape_o,
  output logic       is_seg_o,
  output logic [2:0] seg_code_o,
  output logic       is_rep_o,
  output logic [1:0] rep_code_o,
  output logic       is_opsize_o,
  output logic       is_lock_o
);

  // Decode the byte against the prefix table.
  always_comb begin
    is_escape_o = 1'b0;
    is_seg_o    = 1'b0;
    seg_code_o  = SEG_ES;
    is_rep_o    = 1'b0;
    rep_code_o  = REP_NONE;
    is_opsize_o = 1'b0;
    is_lock_o   = 1'b0;
    case (byte_i)
      PFX_ES:     begin is_seg_o = 1'b1; seg_code_o = SEG_ES; end
      PFX_CS:     begin is_seg_o = 1'b1; seg_code_o = SEG_CS; end
      PFX_SS:     begin is_seg_o = 1'b1; seg_code_o = SEG_SS; end
      PFX_DS:     begin is_seg_o = 1'b1; seg_code_o = SEG_DS; end
      PFX_FS:     begin is_seg_o = 1'b1; seg_code_o = SEG_FS; end
      PFX_GS:     begin is_seg_o = 1'b1; seg_code_o = SEG_GS; end
      PFX_OPSIZE: is_opsize_o = 1'b1;
      PFX_LOCK:   is_lock_o   = 1'b1;
      PFX_REPNE:  begin is_rep_o = 1'b1; rep_code_o = REP_NE; end
      PFX_REP:    begin is_rep_o = 1'b1; rep_code_o = REP_E; end
      ESC_0F:     is_escape_o = 1'b1;
      default:    ;
    endcase
    is_prefix_o = is_seg_o | is_rep_o | is_opsize_o | is_lock_o;
  end

endmodule

// File: rtl/opcode_extract.sv
// Opcode extractor: consumes legacy prefixes and an optional 0F escape
// from a byte stream and holds the decoded opcode for the control store.
// Build option: OPCODE_PREFIX_CHECK_EN enables the prefix-limit fault
// (more than four prefixes); otherwise fault is tied low.
//
// state  | meaning
// S_PFX  | scanning prefix bytes, or waiting for the opcode byte
// S_ESC  | 0F seen, next accepted byte is the second opcode byte
// S_HOLD | opcode held on the output until the control store takes it
module opcode_extract
  import decode_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  opcode_extract_if.slave  bus
);

  state_e     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic       size_q, size_d;
  logic       opsize_q, opsize_d;
  logic [1:0] rep_q, rep_d;
  logic       lock_q, lock_d;
  logic       seg_ovr_q, seg_ovr_d;
  logic [2:0] seg_q, seg_d;
  logic [2:0] cnt_q, cnt_d;

  logic       byte_ready;
  logic       op_valid;
  logic       fault;

  logic       is_prefix, is_escape, is_seg, is_rep, is_opsize, is_lock;
  logic [2:0] seg_code;
  logic [1:0] rep_code;

  prefix_classify u_classify (
    .byte_i      (bus.byte_data),
    .is_prefix_o (is_prefix),
    .is_escape_o (is_escape),
    .is_seg_o    (is_seg),
    .seg_code_o  (seg_code),
    .is_rep_o    (is_rep),
    .rep_code_o  (rep_code),
    .is_opsize_o (is_opsize),
    .is_lock_o   (is_lock)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PFX;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything, including a handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PFX: begin
        if (bus.byte_valid) begin
          if (is_escape)       state_d = S_ESC;
          else if (!is_prefix) state_d = S_HOLD;
        end
      end
      S_ESC:   if (bus.byte_valid) state_d = S_HOLD;
      S_HOLD:  if (bus.op_ready)   state_d = S_PFX;
      default: state_d = S_PFX;
    endcase
    if (flush) state_d = S_PFX;
  end

  // Handshake and fault outputs, decoded from the current state only.
  always_comb begin
    byte_ready = (state_q != S_HOLD);
    op_valid   = (state_q == S_HOLD);
`ifdef OPCODE_PREFIX_CHECK_EN
    fault      = op_valid && (cnt_q > 3'd4);
`else
    fault      = 1'b0;
`endif
  end

  // Next values for the prefix fields and the opcode latch.
  always_comb begin
    opcode_d  = opcode_q;
    size_d    = size_q;
    opsize_d  = opsize_q;
    rep_d     = rep_q;
    lock_d    = lock_q;
    seg_ovr_d = seg_ovr_q;
    seg_d     = seg_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_PFX: begin
        if (bus.byte_valid) begin
          if (is_prefix) begin
            if (is_seg)    begin seg_ovr_d = 1'b1; seg_d = seg_code; end
            if (is_rep)    rep_d    = rep_code;
            if (is_opsize) opsize_d = 1'b1;
            if (is_lock)   lock_d   = 1'b1;
            cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          end else if (!is_escape) begin
            opcode_d = bus.byte_data;
            size_d   = 1'b0;
          end
        end
      end
      S_ESC: begin
        if (bus.byte_valid) begin
          opcode_d = bus.byte_data;
          size_d   = 1'b1;
        end
      end
      default: ;
    endcase
    // A consumed or flushed instruction starts the next one with no prefixes.
    if (flush || (state_q == S_HOLD && bus.op_ready)) begin
      opsize_d  = 1'b0;
      rep_d     = REP_NONE;
      lock_d    = 1'b0;
      seg_ovr_d = 1'b0;
      seg_d     = SEG_ES;
      cnt_d     = 3'd0;
    end
  end

  // Prefix field and opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= 8'h00;
      size_q    <= 1'b0;
      opsize_q  <= 1'b0;
      rep_q     <= REP_NONE;
      lock_q    <= 1'b0;
      seg_ovr_q <= 1'b0;
      seg_q     <= SEG_ES;
      cnt_q     <= 3'd0;
    end else begin
      opcode_q  <= opcode_d;
      size_q    <= size_d;
      opsize_q  <= opsize_d;
      rep_q     <= rep_d;
      lock_q    <= lock_d;
      seg_ovr_q <= seg_ovr_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.op_valid    = op_valid;
  assign bus.fault       = fault;
  assign bus.opcode      = opcode_q;
  assign bus.opcode_size = size_q;
  assign bus.pfx_opsize  = opsize_q;
  assign bus.pfx_rep     = rep_q;
  assign bus.pfx_lock    = lock_q;
  assign bus.seg_ovr     = seg_ovr_q;
  assign bus.pfx_seg     = seg_q;
  assign bus.pfx_count   = cnt_q;

endmodule

// File: tb/tb_opcode_extract.sv
// Bench for opcode_extract: directed instruction sequences with literal
// expectations, then randomized traffic against a byte-list reference model.
module tb_opcode_extract;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  opcode_extract_if bus ();

  opcode_extract dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the raw bytes of the instruction in progress; decodes the whole
  // list once it forms a complete instruction.
  logic [7:0] ibytes[$];
  bit         held = 0;
  logic [7:0] e_opc;
  logic       e_sz, e_opsz, e_lock, e_sego;
  logic [1:0] e_rep;
  logic [2:0] e_seg;
  int         e_cnt;

  function automatic bit is_pfx(input logic [7:0] b);
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF0, 8'hF2, 8'hF3};
  endfunction

  task automatic model_push(input logic [7:0] b);
    int i;
    ibytes.push_back(b);
    i = 0;
    while (i < ibytes.size() && is_pfx(ibytes[i])) i++;
    if (i == ibytes.size()) return;
    if (ibytes[i] == 8'h0F && ibytes.size() != i + 2) return;
    e_opsz = 0; e_lock = 0; e_sego = 0; e_rep = 2'b00; e_seg = 3'd0;
    for (int k = 0; k < i; k++) begin
      case (ibytes[k])
        8'h26: begin e_sego = 1; e_seg = 3'd0; end
        8'h2E: begin e_sego = 1; e_seg = 3'd1; end
        8'h36: begin e_sego = 1; e_seg = 3'd2; end
        8'h3E: begin e_sego = 1; e_seg = 3'd3; end
        8'h64: begin e_sego = 1; e_seg = 3'd4; end
        8'h65: begin e_sego = 1; e_seg = 3'd5; end
        8'h66: e_opsz = 1;
        8'hF0: e_lock = 1;
        8'hF2: e_rep = 2'b01;
        8'hF3: e_rep = 2'b10;
        default: ;
      endcase
    end
    e_cnt = (i > 7) ? 7 : i;
    e_sz  = (ibytes[i] == 8'h0F);
    e_opc = e_sz ? ibytes[i+1] : ibytes[i];
    held  = 1;
  endtask

  // Compare process: checks outputs mid-cycle against the model, then
  // advances the model with the inputs that the next rising edge samples.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      ibytes.delete();
      held = 0;
      chk("rst_op_valid", {31'd0, bus.op_valid}, 0);
      chk("rst_opcode", {24'd0, bus.opcode}, 0);
      chk("rst_pfx", {bus.opcode_size, bus.pfx_opsize, bus.pfx_rep, bus.pfx_lock,
                      bus.seg_ovr, bus.pfx_seg, bus.pfx_count, bus.fault}, 0);
    end else begin
      chk("byte_ready", {31'd0, bus.byte_ready}, {31'd0, !held});
      chk("op_valid", {31'd0, bus.op_valid}, {31'd0, held});
      if (held) begin
        chk("opcode", {24'd0, bus.opcode}, {24'd0, e_opc});
        chk("opcode_size", {31'd0, bus.opcode_size}, {31'd0, e_sz});
        chk("pfx_opsize", {31'd0, bus.pfx_opsize}, {31'd0, e_opsz});
        chk("pfx_rep", {30'd0, bus.pfx_rep}, {30'd0, e_rep});
        chk("pfx_lock", {31'd0, bus.pfx_lock}, {31'd0, e_lock});
        chk("seg_ovr", {31'd0, bus.seg_ovr}, {31'd0, e_sego});
        if (e_sego) chk("pfx_seg", {29'd0, bus.pfx_seg}, {29'd0, e_seg});
        chk("pfx_count", {29'd0, bus.pfx_count}, e_cnt);
`ifdef OPCODE_PREFIX_CHECK_EN
        chk("fault", {31'd0, bus.fault}, {31'd0, (e_cnt > 4)});
`else
        chk("fault", {31'd0, bus.fault}, 0);
`endif
      end else begin
        chk("fault_idle", {31'd0, bus.fault}, 0);
      end
      if (flush) begin
        ibytes.delete();
        held = 0;
      end else if (held) begin
        if (bus.op_ready) begin
          held = 0;
          ibytes.delete();
        end
      end else if (bus.byte_valid) begin
        model_push(bus.byte_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pfx_tab [10] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64,
                               8'h65, 8'h66, 8'hF0, 8'hF2, 8'hF3};

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.op_ready   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // 66 F3 A5
    put(8'h66); put(8'hF3); put(8'hA5);
    bus.byte_valid = 1'b0;
    chk("t1_op_valid", {31'd0, bus.op_valid}, 1);
    chk("t1_opcode", {24'd0, bus.opcode}, 32'hA5);
    chk("t1_size", {31'd0, bus.opcode_size}, 0);
    chk("t1_opsize", {31'd0, bus.pfx_opsize}, 1);
    chk("t1_rep", {30'd0, bus.pfx_rep}, 2);
    chk("t1_count", {29'd0, bus.pfx_count}, 2);
    idle(1);

    // 0F 66: escaped, 66 is an opcode here
    put(8'h0F); put(8'h66);
    bus.byte_valid = 1'b0;
    chk("t2_opcode", {24'd0, bus.opcode}, 32'h66);
    chk("t2_size", {31'd0, bus.opcode_size}, 1);
    chk("t2_count", {29'd0, bus.pfx_count}, 0);
    chk("t2_opsize", {31'd0, bus.pfx_opsize}, 0);
    idle(1);

    // 2E 64 8B with the control store stalled for three cycles
    bus.op_ready = 1'b0;
    put(8'h2E); put(8'h64); put(8'h8B);
    bus.byte_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t3_opcode", {24'd0, bus.opcode}, 32'h8B);
      chk("t3_seg", {29'd0, bus.pfx_seg}, 4);
      chk("t3_seg_ovr", {31'd0, bus.seg_ovr}, 1);
      chk("t3_byte_ready", {31'd0, bus.byte_ready}, 0);
      if (c < 3) @(negedge clk);
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    chk("t3_released", {30'd0, bus.op_valid, bus.byte_ready}, 1);

    // five ES prefixes then NOP
    for (int k = 0; k < 5; k++) put(8'h26);
    put(8'h90);
    bus.byte_valid = 1'b0;
    chk("t4_count", {29'd0, bus.pfx_count}, 5);
`ifdef OPCODE_PREFIX_CHECK_EN
    chk("t4_fault", {31'd0, bus.fault}, 1);
`else
    chk("t4_fault", {31'd0, bus.fault}, 0);
`endif
    idle(1);

    // LOCK then flush: the lock must not leak into the next instruction
    put(8'hF0);
    bus.byte_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_no_op_valid", {31'd0, bus.op_valid}, 0);
    put(8'h90);
    bus.byte_valid = 1'b0;
    chk("t5_opcode", {24'd0, bus.opcode}, 32'h90);
    chk("t5_lock", {31'd0, bus.pfx_lock}, 0);
    chk("t5_count", {29'd0, bus.pfx_count}, 0);
    idle(1);

    // reset while waiting for the escaped byte
    put(8'h0F);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_opcode", {24'd0, bus.opcode}, 0);
    chk("t6_rst_op_valid", {31'd0, bus.op_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h0F); put(8'h05);
    bus.byte_valid = 1'b0;
    chk("t6_opcode", {24'd0, bus.opcode}, 32'h05);
    chk("t6_size", {31'd0, bus.opcode_size}, 1);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.byte_valid = (r < 75);
      r = int'($urandom_range(0, 99));
      if (r < 55)      bus.byte_data = pfx_tab[$urandom_range(0, 9)];
      else if (r < 65) bus.byte_data = 8'h0F;
      else             bus.byte_data = 8'($urandom);
      bus.op_ready = ($urandom_range(0, 99) < 60);
      flush        = ($urandom_range(0, 99) < 3);
      rst_n        = !($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    flush = 1'b0;
    bus.op_ready = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
